// File: rtl/text_pkg.sv
`default_nettype none
// ----------------------------------------------------------------
// Package : text_pkg
// Brief   : ASCII constants, buffer FSM states, row-wrap helper
// Rev     : 1.0
// ----------------------------------------------------------------
package text_pkg;

  localparam logic [7:0] BS        = 8'h08;
  localparam logic [7:0] LF        = 8'h0A;
  localparam logic [7:0] CR        = 8'h0D;
  localparam logic [7:0] BLANK_DEF = 8'h20;
  localparam logic [7:0] PRINT_LO  = 8'h20;
  localparam logic [7:0] PRINT_HI  = 8'h7E;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_CLEAR = 2'd2
  } state_t;

  // Both operands are below rows, so one conditional subtract wraps the sum.
  function automatic int row_wrap(input int sum, input int rows);
    return (sum >= rows) ? (sum - rows) : sum;
  endfunction

endpackage
`default_nettype wire

// File: rtl/key_text_buffer_if.sv
`default_nettype none
// ----------------------------------------------------------------
// Interface : key_text_buffer_if
// Brief     : character input, display read port and status of the text buffer
// Rev       : 1.0
// ----------------------------------------------------------------
interface key_text_buffer_if #(
  parameter int ROWS = 30,
  parameter int COLS = 70
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);

  logic [7:0]    asc;
  logic          en;
  logic [RW-1:0] rd_row;
  logic [CW-1:0] rd_col;
  logic [7:0]    rd_data;
  logic [RW-1:0] cur_row;
  logic [CW-1:0] cur_col;
  logic          busy;
  logic          drop;

  modport master (
    output asc, en, rd_row, rd_col,
    input  rd_data, cur_row, cur_col, busy, drop
  );

  modport slave (
    input  asc, en, rd_row, rd_col,
    output rd_data, cur_row, cur_col, busy, drop
  );
endinterface
`default_nettype wire

// File: rtl/text_ram.sv
`default_nettype none
// ----------------------------------------------------------------
// Module : text_ram
// Brief  : simple dual-port character RAM, registered read (old data on collision)
// Rev    : 1.0
// ----------------------------------------------------------------
module text_ram #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic          clk,
  input  wire logic          clr,
  input  wire logic          we,
  input  wire logic [AW-1:0] waddr,
  input  wire logic [7:0]    wdata,
  input  wire logic [AW-1:0] raddr,
  output logic      [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= 8'h00;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule
`default_nettype wire

// File: rtl/key_text_buffer.sv
`default_nettype none
// ----------------------------------------------------------------
// Module : key_text_buffer
// Brief  : keyboard-fed ROWS x COLS text screen with cursor and circular scroll
// Rev    : 1.0
// ----------------------------------------------------------------
module key_text_buffer
  import text_pkg::*;
#(
  parameter int         ROWS  = 30,
  parameter int         COLS  = 70,
  parameter logic [7:0] BLANK = BLANK_DEF
) (
  input wire logic        clk,
  input wire logic        clr,
  key_text_buffer_if.slave bus
);

  localparam int RW    = $clog2(ROWS);
  localparam int CW    = $clog2(COLS);
  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [RW-1:0] LAST_ROW  = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL  = CW'(COLS - 1);
  localparam logic [AW-1:0] LAST_CELL = AW'(DEPTH - 1);

  // Display row r lives in physical row (top + r) mod ROWS.
  function automatic logic [AW-1:0] cell_addr(input logic [RW-1:0] t,
                                              input logic [RW-1:0] r,
                                              input logic [CW-1:0] c);
    return AW'(row_wrap(int'(t) + int'(r), ROWS) * COLS + int'(c));
  endfunction

  state_t        state, state_n;
  logic [RW-1:0] top, top_n;
  logic [RW-1:0] row, row_n;
  logic [CW-1:0] col, col_n;
  logic [CW-1:0] clr_cnt, clr_cnt_n;
  logic [AW-1:0] init_cnt, init_cnt_n;
  logic          pend_v, pend_v_n;
  logic [7:0]    pend_d, pend_d_n;
  logic          en_q;
  logic          drop_r, drop_n;

  logic          ev;
  logic          consume;
  logic          newline;
  logic          we;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;

  assign ev = bus.en & ~en_q & (bus.asc != 8'h00);

  always_ff @(posedge clk) begin
    if (clr) begin
      state    <= ST_INIT;
      top      <= '0;
      row      <= '0;
      col      <= '0;
      clr_cnt  <= '0;
      init_cnt <= '0;
      pend_v   <= 1'b0;
      pend_d   <= 8'h00;
      en_q     <= 1'b0;
      drop_r   <= 1'b0;
    end else begin
      state    <= state_n;
      top      <= top_n;
      row      <= row_n;
      col      <= col_n;
      clr_cnt  <= clr_cnt_n;
      init_cnt <= init_cnt_n;
      pend_v   <= pend_v_n;
      pend_d   <= pend_d_n;
      en_q     <= bus.en;
      drop_r   <= drop_n;
    end
  end

  always_comb begin
    state_n    = state;
    top_n      = top;
    row_n      = row;
    col_n      = col;
    clr_cnt_n  = clr_cnt;
    init_cnt_n = init_cnt;
    pend_v_n   = pend_v;
    pend_d_n   = pend_d;
    drop_n     = 1'b0;
    consume    = 1'b0;
    newline    = 1'b0;
    we         = 1'b0;
    waddr      = cell_addr(top, row, col);
    wdata      = BLANK;

    case (state)
      ST_INIT: begin
        we    = 1'b1;
        waddr = init_cnt;
        if (init_cnt == LAST_CELL) begin
          state_n = ST_IDLE;
        end else begin
          init_cnt_n = init_cnt + 1'b1;
        end
      end
      ST_IDLE: begin
        if (pend_v) begin
          consume = 1'b1;
          if (pend_d >= PRINT_LO && pend_d <= PRINT_HI) begin
            we    = 1'b1;
            wdata = pend_d;
            if (col == LAST_COL) begin
              newline = 1'b1;
            end else begin
              col_n = col + 1'b1;
            end
          end else if (pend_d == BS) begin
            if (col != '0) begin
              col_n = col - 1'b1;
              we    = 1'b1;
              waddr = cell_addr(top, row, col - 1'b1);
            end
          end else if (pend_d == CR || pend_d == LF) begin
            newline = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        we    = 1'b1;
        waddr = cell_addr(top, LAST_ROW, clr_cnt);
        if (clr_cnt == LAST_COL) begin
          state_n = ST_IDLE;
        end else begin
          clr_cnt_n = clr_cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_INIT;
      end
    endcase

    // At the bottom row a newline scrolls by advancing top; the old top row is blanked.
    if (newline) begin
      col_n = '0;
      if (row != LAST_ROW) begin
        row_n = row + 1'b1;
      end else begin
        top_n     = RW'(row_wrap(int'(top) + 1, ROWS));
        state_n   = ST_CLEAR;
        clr_cnt_n = '0;
      end
    end

    if (consume) begin
      pend_v_n = 1'b0;
    end
    if (ev) begin
      if (state == ST_INIT || (pend_v && !consume)) begin
        drop_n = 1'b1;
      end else begin
        pend_v_n = 1'b1;
        pend_d_n = bus.asc;
      end
    end
  end

  text_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .clr  (clr),
    .we   (we),
    .waddr(waddr),
    .wdata(wdata),
    .raddr(cell_addr(top, bus.rd_row, bus.rd_col)),
    .rdata(bus.rd_data)
  );

  assign bus.cur_row = row;
  assign bus.cur_col = col;
  assign bus.busy    = (state != ST_IDLE);
  assign bus.drop    = drop_r;

endmodule
`default_nettype wire

// File: tb/tb_key_text_buffer.sv
`default_nettype none
// ----------------------------------------------------------------
// Module : tb_key_text_buffer
// Brief  : directed self-checking bench for key_text_buffer at 4x4
// Rev    : 1.0
// ----------------------------------------------------------------
module tb_key_text_buffer;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic clk = 1'b0;
  logic clr;
  int   errors  = 0;
  int   checks  = 0;
  int   drop_hi = 0;

  always #5 clk = ~clk;

  key_text_buffer_if #(.ROWS(ROWS), .COLS(COLS)) bus();

  key_text_buffer #(
    .ROWS (ROWS),
    .COLS (COLS),
    .BLANK(8'h20)
  ) dut (
    .clk(clk),
    .clr(clr),
    .bus(bus)
  );

  always @(negedge clk) begin
    if (bus.drop === 1'b1) drop_hi++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] c);
    bus.asc = c;
    bus.en  = 1'b1;
    tick(1);
    bus.en  = 1'b0;
    tick(2);
  endtask

  task automatic read_cell(input int r, input int c, output logic [7:0] v);
    bus.rd_row = 2'(r);
    bus.rd_col = 2'(c);
    tick(1);
    v = bus.rd_data;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (bus.busy === 1'b1 && n < 100) begin
      n++;
      tick(1);
    end
  endtask

  task automatic do_reset;
    int n;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    count_busy(n);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_timeout: busy=%b after %0d cycles, required 0", bus.busy, n);
    end
  endtask

  task automatic test_reset;
    int n;
    logic [7:0] v;
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    checks++;
    if (bus.rd_data !== 8'h00) begin
      errors++; $display("FAIL reset_rd_data: got %h, required 00", bus.rd_data);
    end
    checks++;
    if (bus.cur_row !== 2'd0 || bus.cur_col !== 2'd0) begin
      errors++; $display("FAIL reset_cursor: got (%0d,%0d), required (0,0)", bus.cur_row, bus.cur_col);
    end
    count_busy(n);
    checks++;
    if (n !== 16) begin
      errors++; $display("FAIL reset_busy_len: got %0d cycles, required 16", n);
    end
    for (int i = 0; i < 16; i++) begin
      read_cell(i / 4, i % 4, v);
      checks++;
      if (v !== 8'h20) begin
        errors++; $display("FAIL reset_cell(%0d,%0d): got %h, required 20", i / 4, i % 4, v);
      end
    end
  endtask

  task automatic test_type_ab;
    logic [7:0] v;
    int d0 = drop_hi;
    send("A");
    send("B");
    read_cell(0, 0, v);
    checks++;
    if (v !== "A") begin errors++; $display("FAIL ab_cell00: got %h, required 41", v); end
    read_cell(0, 1, v);
    checks++;
    if (v !== "B") begin errors++; $display("FAIL ab_cell01: got %h, required 42", v); end
    checks++;
    if (bus.cur_row !== 2'd0 || bus.cur_col !== 2'd2) begin
      errors++; $display("FAIL ab_cursor: got (%0d,%0d), required (0,2)", bus.cur_row, bus.cur_col);
    end
    checks++;
    if (drop_hi - d0 !== 0) begin
      errors++; $display("FAIL ab_drop: got %0d drop cycles, required 0", drop_hi - d0);
    end
  endtask

  task automatic test_hold;
    logic [7:0] v;
    do_reset();
    bus.asc = "C";
    bus.en  = 1'b1;
    tick(100);
    bus.en  = 1'b0;
    tick(2);
    checks++;
    if (bus.cur_row !== 2'd0 || bus.cur_col !== 2'd1) begin
      errors++; $display("FAIL hold_cursor: got (%0d,%0d), required (0,1)", bus.cur_row, bus.cur_col);
    end
    read_cell(0, 0, v);
    checks++;
    if (v !== "C") begin errors++; $display("FAIL hold_cell00: got %h, required 43", v); end
    read_cell(0, 1, v);
    checks++;
    if (v !== 8'h20) begin errors++; $display("FAIL hold_cell01: got %h, required 20", v); end
  endtask

  task automatic test_wrap_backspace;
    logic [7:0] v;
    string s = "ABCDE";
    do_reset();
    for (int i = 0; i < 5; i++) send(s[i]);
    for (int c = 0; c < 4; c++) begin
      read_cell(0, c, v);
      checks++;
      if (v !== s[c]) begin errors++; $display("FAIL wrap_row0_col%0d: got %h, required %h", c, v, s[c]); end
    end
    read_cell(1, 0, v);
    checks++;
    if (v !== "E") begin errors++; $display("FAIL wrap_cell10: got %h, required 45", v); end
    checks++;
    if (bus.cur_row !== 2'd1 || bus.cur_col !== 2'd1) begin
      errors++; $display("FAIL wrap_cursor: got (%0d,%0d), required (1,1)", bus.cur_row, bus.cur_col);
    end
    send(8'h08);
    send(8'h08);
    read_cell(1, 0, v);
    checks++;
    if (v !== 8'h20) begin errors++; $display("FAIL bs_cell10: got %h, required 20", v); end
    checks++;
    if (bus.cur_row !== 2'd1 || bus.cur_col !== 2'd0) begin
      errors++; $display("FAIL bs_cursor: got (%0d,%0d), required (1,0)", bus.cur_row, bus.cur_col);
    end
    send(8'h08);
    checks++;
    if (bus.cur_row !== 2'd1 || bus.cur_col !== 2'd0) begin
      errors++; $display("FAIL bs_col0_cursor: got (%0d,%0d), required (1,0)", bus.cur_row, bus.cur_col);
    end
    read_cell(0, 3, v);
    checks++;
    if (v !== "D") begin errors++; $display("FAIL bs_no_reverse: got %h, required 44", v); end
  endtask

  task automatic test_scroll;
    logic [7:0] v;
    int n;
    string s   = "WXYZ12345678ab";
    string exp = "12345678ab      ";
    do_reset();
    for (int i = 0; i < 14; i++) send(s[i]);
    checks++;
    if (bus.cur_row !== 2'd3 || bus.cur_col !== 2'd2) begin
      errors++; $display("FAIL scroll_pre_cursor: got (%0d,%0d), required (3,2)", bus.cur_row, bus.cur_col);
    end
    read_cell(0, 0, v);
    checks++;
    if (v !== "W") begin errors++; $display("FAIL scroll_pre_cell00: got %h, required 57", v); end
    bus.asc = 8'h0D;
    bus.en  = 1'b1;
    tick(1);
    bus.en  = 1'b0;
    tick(1);
    count_busy(n);
    checks++;
    if (n !== 4) begin errors++; $display("FAIL scroll_busy_len: got %0d cycles, required 4", n); end
    checks++;
    if (bus.cur_row !== 2'd3 || bus.cur_col !== 2'd0) begin
      errors++; $display("FAIL scroll_cursor: got (%0d,%0d), required (3,0)", bus.cur_row, bus.cur_col);
    end
    for (int i = 0; i < 16; i++) begin
      read_cell(i / 4, i % 4, v);
      checks++;
      if (v !== exp[i]) begin
        errors++; $display("FAIL scroll_cell(%0d,%0d): got %h, required %h", i / 4, i % 4, v, exp[i]);
      end
    end
  endtask

  task automatic test_clear_events;
    logic [7:0] v;
    int d0 = drop_hi;
    string exp = "5678ab      PR  ";
    bus.asc = 8'h0D; bus.en = 1'b1; tick(1);
    bus.en  = 1'b0;  tick(1);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL clr_ev_busy: got %b, required 1", bus.busy); end
    bus.asc = "P"; bus.en = 1'b1; tick(1);
    bus.en  = 1'b0; tick(1);
    bus.asc = "Q"; bus.en = 1'b1; tick(1);
    checks++;
    if (bus.drop !== 1'b1) begin errors++; $display("FAIL clr_ev_drop_q: got %b, required 1", bus.drop); end
    bus.en = 1'b0; tick(1);
    checks++;
    if (bus.busy !== 1'b0 || bus.drop !== 1'b0) begin
      errors++; $display("FAIL clr_ev_end: got busy=%b drop=%b, required 0 0", bus.busy, bus.drop);
    end
    // New edge lands in the same cycle the pending 'P' is consumed.
    bus.asc = "R"; bus.en = 1'b1; tick(1);
    checks++;
    if (bus.drop !== 1'b0) begin errors++; $display("FAIL b2b_drop: got %b, required 0", bus.drop); end
    bus.en = 1'b0; tick(2);
    checks++;
    if (drop_hi - d0 !== 1) begin
      errors++; $display("FAIL clr_ev_drop_len: got %0d drop cycles, required 1", drop_hi - d0);
    end
    checks++;
    if (bus.cur_row !== 2'd3 || bus.cur_col !== 2'd2) begin
      errors++; $display("FAIL clr_ev_cursor: got (%0d,%0d), required (3,2)", bus.cur_row, bus.cur_col);
    end
    for (int i = 0; i < 16; i++) begin
      read_cell(i / 4, i % 4, v);
      checks++;
      if (v !== exp[i]) begin
        errors++; $display("FAIL clr_ev_cell(%0d,%0d): got %h, required %h", i / 4, i % 4, v, exp[i]);
      end
    end
  endtask

  task automatic test_clr_mid_clear;
    logic [7:0] v;
    int n;
    bus.asc = 8'h0D; bus.en = 1'b1; tick(1);
    bus.en  = 1'b0;  tick(2);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL midclr_busy: got %b, required 1", bus.busy); end
    clr = 1'b1; tick(1); clr = 1'b0;
    count_busy(n);
    checks++;
    if (n !== 16) begin errors++; $display("FAIL midclr_busy_len: got %0d cycles, required 16", n); end
    checks++;
    if (bus.cur_row !== 2'd0 || bus.cur_col !== 2'd0) begin
      errors++; $display("FAIL midclr_cursor: got (%0d,%0d), required (0,0)", bus.cur_row, bus.cur_col);
    end
    checks++;
    if (dut.top !== 2'd0) begin errors++; $display("FAIL midclr_top: got %0d, required 0", dut.top); end
    for (int i = 0; i < 16; i++) begin
      read_cell(i / 4, i % 4, v);
      checks++;
      if (v !== 8'h20) begin
        errors++; $display("FAIL midclr_cell(%0d,%0d): got %h, required 20", i / 4, i % 4, v);
      end
    end
  endtask

  task automatic test_init_drop_codes;
    logic [7:0] v;
    int d0 = drop_hi;
    clr = 1'b1; tick(1); clr = 1'b0;
    bus.asc = "Z"; bus.en = 1'b1; tick(1);
    bus.en = 1'b0;
    do_reset();
    checks++;
    if (drop_hi - d0 !== 1) begin
      errors++; $display("FAIL init_drop: got %0d drop cycles, required 1", drop_hi - d0);
    end
    send(8'h00);
    send(8'h01);
    send(8'h7F);
    checks++;
    if (bus.cur_row !== 2'd0 || bus.cur_col !== 2'd0) begin
      errors++; $display("FAIL ignored_codes_cursor: got (%0d,%0d), required (0,0)", bus.cur_row, bus.cur_col);
    end
    send(8'h7E);
    read_cell(0, 0, v);
    checks++;
    if (v !== 8'h7E) begin errors++; $display("FAIL tilde_cell00: got %h, required 7e", v); end
    checks++;
    if (bus.cur_col !== 2'd1 || drop_hi - d0 !== 1) begin
      errors++; $display("FAIL tilde_state: got col=%0d drops=%0d, required col=1 drops=1", bus.cur_col, drop_hi - d0);
    end
  endtask

  initial begin
    clr        = 1'b1;
    bus.asc    = 8'h00;
    bus.en     = 1'b0;
    bus.rd_row = '0;
    bus.rd_col = '0;
    test_reset();
    test_type_ab();
    test_hold();
    test_wrap_backspace();
    test_scroll();
    test_clear_events();
    test_clr_mid_clear();
    test_init_drop_codes();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
